// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the EX-stage forwarding logic.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;

  // Operand source encoding. Zero selects the register file, and i+1 selects stage i.
  localparam int unsigned SEL_RF = 0;

  typedef enum logic [0:0] {
    StRun,
    StStall
  } fwd_state_e;

endpackage

// File: rtl/fwd_operand_unit_if.sv
// Operand-forwarding bus. It carries the decode-side request, the downstream stage results and
// the registered operands going to the ALU.
interface fwd_operand_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned STAGES = 2
);
  localparam int unsigned SelW = $clog2(STAGES + 1);

  logic                       hold;
  logic [REG_AW-1:0]          rs_a;
  logic [REG_AW-1:0]          rs_b;
  logic [DATA_W-1:0]          rf_a;
  logic [DATA_W-1:0]          rf_b;
  logic [STAGES*REG_AW-1:0]   stg_rd;
  logic [STAGES-1:0]          stg_we;
  logic [STAGES*DATA_W-1:0]   stg_data;
  logic                       stg_load0;
  logic                       in_valid;
  logic [DATA_W-1:0]          op_a;
  logic [DATA_W-1:0]          op_b;
  logic [SelW-1:0]            sel_a;
  logic [SelW-1:0]            sel_b;
  logic                       op_valid;
  logic                       stall_out;

  modport master (
    output hold, rs_a, rs_b, rf_a, rf_b, stg_rd, stg_we, stg_data, stg_load0, in_valid,
    input  op_a, op_b, sel_a, sel_b, op_valid, stall_out
  );

  modport slave (
    input  hold, rs_a, rs_b, rf_a, rf_b, stg_rd, stg_we, stg_data, stg_load0, in_valid,
    output op_a, op_b, sel_a, sel_b, op_valid, stall_out
  );

endinterface

// File: rtl/fwd_select.sv
// Per-operand forwarding select. This is a priority match of one source register against all
// downstream destinations, and the youngest stage wins.
module fwd_select #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned SelW    = $clog2(STAGES + 1)
) (
  input  logic [REG_AW-1:0]        rs,
  input  logic [DATA_W-1:0]        rf,
  input  logic [STAGES*REG_AW-1:0] stg_rd,
  input  logic [STAGES-1:0]        stg_we,
  input  logic [STAGES*DATA_W-1:0] stg_data,
  output logic [DATA_W-1:0]        data,
  output logic [SelW-1:0]          sel
);
  import cpu_pkg::*;

  logic is_zero;

  // Scan from oldest to youngest so that a younger match overwrites an older one.
  always_comb begin
    data    = rf;
    sel     = SelW'(SEL_RF);
    is_zero = (ZERO_REG != 0) && (rs == '0);
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (stg_we[i] && (stg_rd[i*REG_AW +: REG_AW] == rs)) begin
        data = stg_data[i*DATA_W +: DATA_W];
        sel  = SelW'(i + 1);
      end
    end
    // A hard-wired zero register ignores both the forwarding paths and the register-file read.
    if (is_zero) begin
      data = '0;
      sel  = SelW'(SEL_RF);
    end
  end

endmodule

// File: rtl/fwd_operand_unit.sv
// EX-stage operand forwarding unit. It forwards both operands from the youngest matching stage,
// registers them for the ALU and stalls fetch/decode on load-use hazards.
module fwd_operand_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clock,
  input  logic               reset,
  fwd_operand_unit_if.slave  bus
);
  import cpu_pkg::*;

  localparam int unsigned SelW = $clog2(STAGES + 1);
  localparam int unsigned CntW = 3;

  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic [SelW-1:0]   fsel_a, fsel_b;
  logic              hazard, stall, capture;

  fwd_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [SelW-1:0]   sel_a_q, sel_b_q;
  logic              op_valid_q;

  fwd_select #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .ZERO_REG (ZERO_REG)
  ) u_sel_a (
    .rs       (bus.rs_a),
    .rf       (bus.rf_a),
    .stg_rd   (bus.stg_rd),
    .stg_we   (bus.stg_we),
    .stg_data (bus.stg_data),
    .data     (fwd_a),
    .sel      (fsel_a)
  );

  fwd_select #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .ZERO_REG (ZERO_REG)
  ) u_sel_b (
    .rs       (bus.rs_b),
    .rf       (bus.rf_b),
    .stg_rd   (bus.stg_rd),
    .stg_we   (bus.stg_we),
    .stg_data (bus.stg_data),
    .data     (fwd_b),
    .sel      (fsel_b)
  );

  // Selecting stage 0 means stage 0 was the youngest match. If stage 0 is a load, its data is
  // not ready yet.
  always_comb begin
    hazard = bus.in_valid && bus.stg_load0 &&
             ((fsel_a == SelW'(1)) || (fsel_b == SelW'(1)));
  end

  // Stall FSM next state. The hazard cycle itself counts as the first of the LOAD_LAT stall cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = StStall;
            cnt_d   = CntW'(LOAD_LAT - 1);
          end
        end
      end
      StStall: begin
        stall = 1'b1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // The stall request and the operand capture enable.
  always_comb begin
    bus.stall_out = stall && !reset;
    capture       = bus.in_valid && !stall;
  end

  // State and operand registers. Reset takes priority over hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      op_valid_q <= 1'b0;
    end else if (!bus.hold) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_valid_q <= capture;
      if (capture) begin
        op_a_q  <= fwd_a;
        op_b_q  <= fwd_b;
        sel_a_q <= fsel_a;
        sel_b_q <= fsel_b;
      end
    end
  end

  // Drive the registered operands onto the bus.
  always_comb begin
    bus.op_a     = op_a_q;
    bus.op_b     = op_b_q;
    bus.sel_a    = sel_a_q;
    bus.sel_b    = sel_b_q;
    bus.op_valid = op_valid_q;
  end

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Directed bench for fwd_operand_unit with LOAD_LAT=2 and ZERO_REG=1.
module tb_fwd_operand_unit;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fwd_operand_unit_if #(.DATA_W(16), .REG_AW(4), .STAGES(2)) bus ();

  fwd_operand_unit #(
    .DATA_W   (16),
    .REG_AW   (4),
    .STAGES   (2),
    .LOAD_LAT (2),
    .ZERO_REG (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so outputs and inputs sit away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.stg_we    = 2'b00;
    bus.stg_load0 = 1'b0;
    bus.stg_rd    = '0;
    bus.stg_data  = '0;
  endtask

  initial begin
    reset    = 1'b1;
    bus.hold = 1'b0;
    bus.rs_a = '0;
    bus.rs_b = '0;
    bus.rf_a = '0;
    bus.rf_b = '0;
    idle();
    tick();
    tick();
    check("rst_op_a", bus.op_a, 0);
    check("rst_op_b", bus.op_b, 0);
    check("rst_sel_a", bus.sel_a, 0);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_stall", bus.stall_out, 0);
    reset = 1'b0;

    // No match: both operands come from the register file.
    bus.in_valid = 1'b1;
    bus.rs_a = 4'd3; bus.rf_a = 16'h1111;
    bus.rs_b = 4'd7; bus.rf_b = 16'h2222;
    #1 check("nomatch_stall", bus.stall_out, 0);
    tick();
    check("nomatch_op_a", bus.op_a, 16'h1111);
    check("nomatch_sel_a", bus.sel_a, 0);
    check("nomatch_op_b", bus.op_b, 16'h2222);
    check("nomatch_valid", bus.op_valid, 1);

    // Priority: both stages write r5, and stage 0 wins.
    bus.rs_a = 4'd6; bus.rf_a = 16'h3333;
    bus.rs_b = 4'd5;
    bus.stg_rd = {4'd5, 4'd5}; bus.stg_we = 2'b11;
    bus.stg_data = {16'hBBBB, 16'hAAAA};
    tick();
    check("prio_op_b", bus.op_b, 16'hAAAA);
    check("prio_sel_b", bus.sel_b, 1);
    check("prio_op_a", bus.op_a, 16'h3333);

    // Stage 1 only, with both operands on the same register.
    bus.rs_a = 4'd5; bus.stg_we = 2'b10;
    tick();
    check("same_op_a", bus.op_a, 16'hBBBB);
    check("same_sel_a", bus.sel_a, 2);
    check("same_op_b", bus.op_b, 16'hBBBB);
    check("same_sel_b", bus.sel_b, 2);

    // Zero register is never forwarded and reads 0.
    bus.rs_a = 4'd0; bus.rf_a = 16'h5555;
    bus.rs_b = 4'd9; bus.rf_b = 16'h4444;
    bus.stg_rd = {4'd1, 4'd0}; bus.stg_we = 2'b01;
    bus.stg_data = {16'h0000, 16'hFFFF};
    tick();
    check("zero_op_a", bus.op_a, 0);
    check("zero_sel_a", bus.sel_a, 0);
    check("zero_op_b", bus.op_b, 16'h4444);

    // No instruction: op_valid drops, and the operands keep their values.
    idle();
    tick();
    check("novalid_valid", bus.op_valid, 0);
    check("novalid_op_b", bus.op_b, 16'h4444);

    // Load-use with LOAD_LAT=2.
    bus.in_valid = 1'b1;
    bus.rs_a = 4'd4; bus.rs_b = 4'd1; bus.rf_b = 16'h0101;
    bus.stg_rd = {4'd0, 4'd4}; bus.stg_we = 2'b01; bus.stg_load0 = 1'b1;
    bus.stg_data = {16'h0000, 16'hDEAD};
    #1 check("lu_stall_c1", bus.stall_out, 1);
    tick();
    check("lu_valid_c1", bus.op_valid, 0);
    check("lu_op_b_kept", bus.op_b, 16'h4444);
    bus.stg_rd = {4'd4, 4'd0}; bus.stg_we = 2'b10; bus.stg_load0 = 1'b0;
    bus.stg_data = {16'h1234, 16'h0000};
    #1 check("lu_stall_c2", bus.stall_out, 1);
    tick();
    check("lu_valid_c2", bus.op_valid, 0);
    check("lu_stall_done", bus.stall_out, 0);
    tick();
    check("lu_op_a", bus.op_a, 16'h1234);
    check("lu_sel_a", bus.sel_a, 2);
    check("lu_op_b", bus.op_b, 16'h0101);
    check("lu_valid", bus.op_valid, 1);

    // Hold with op_valid=1: nothing is captured.
    bus.hold = 1'b1;
    bus.rs_a = 4'd3; bus.rf_a = 16'h7777; bus.stg_we = 2'b00;
    tick();
    check("hold_valid_kept", bus.op_valid, 1);
    check("hold_op_a_kept", bus.op_a, 16'h1234);
    bus.hold = 1'b0;

    // Hold for 3 cycles mid-STALL.
    bus.rs_a = 4'd4;
    bus.stg_rd = {4'd0, 4'd4}; bus.stg_we = 2'b01; bus.stg_load0 = 1'b1;
    tick();
    bus.hold = 1'b1;
    bus.stg_rd = {4'd4, 4'd0}; bus.stg_we = 2'b10; bus.stg_load0 = 1'b0;
    bus.stg_data = {16'h5678, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall", bus.stall_out, 1);
      check("hold_valid", bus.op_valid, 0);
      check("hold_op_a", bus.op_a, 16'h1234);
    end
    bus.hold = 1'b0;
    tick();
    check("hold_rel_stall", bus.stall_out, 0);
    check("hold_rel_valid", bus.op_valid, 0);
    tick();
    check("hold_rel_op_a", bus.op_a, 16'h5678);
    check("hold_rel_sel_a", bus.sel_a, 2);

    // Reset mid-STALL, with hold also asserted.
    bus.stg_rd = {4'd0, 4'd4}; bus.stg_we = 2'b01; bus.stg_load0 = 1'b1;
    tick();
    check("rs_in_stall", bus.stall_out, 1);
    reset = 1'b1; bus.hold = 1'b1;
    bus.stg_we = 2'b00; bus.stg_load0 = 1'b0;
    bus.rs_a = 4'd3; bus.rf_a = 16'h1111;
    #1 check("rs_stall_forced", bus.stall_out, 0);
    tick();
    reset = 1'b0; bus.hold = 1'b0;
    #1;
    check("rs_op_a", bus.op_a, 0);
    check("rs_sel_a", bus.sel_a, 0);
    check("rs_op_b", bus.op_b, 0);
    check("rs_valid", bus.op_valid, 0);
    check("rs_stall", bus.stall_out, 0);
    tick();
    check("rs_run_op_a", bus.op_a, 16'h1111);
    check("rs_run_valid", bus.op_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_operand_unit.md
# fwd_operand_unit

Parametrised EX-stage operand forwarding unit for the 16-bit pipeline. It replaces the fixed two-operand, three-way forwarding muxes with a single block that does three things: compares source register addresses against `STAGES` downstream destination registers, selects the youngest matching result for each operand, and registers both operands for the ALU. It also detects load-use hazards and requests pipeline stall cycles through a small counter FSM.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width
- `REG_AW`, 4, register address width
- `STAGES`, 2, number of forwarding sources; stage 0 is the youngest (ALU output), stage `STAGES-1` the oldest (WB)
- `LOAD_LAT`, 1, bubble cycles required when stage 0 holds a load (1..7)
- `ZERO_REG`, 1, when 1, register address 0 is never forwarded and always reads 0

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `hold` in 1: downstream freeze; all registers and FSM keep their value
- `rs_a`, `rs_b` in `REG_AW` each: source register addresses of the instruction entering EX
- `rf_a`, `rf_b` in `DATA_W` each: register-file read data
- `stg_rd` in `STAGES*REG_AW`: destination address per stage, stage i at bits [i*REG_AW +: REG_AW]
- `stg_we` in `STAGES`: write-enable per stage
- `stg_data` in `STAGES*DATA_W`: result per stage
- `stg_load0` in 1: stage 0 instruction is a load (data not yet valid)
- `in_valid` in 1: instruction present at input
- `op_a`, `op_b` out `DATA_W` each: registered forwarded operands
- `sel_a`, `sel_b` out `$clog2(STAGES+1)` each: registered source; 0 = register file, i+1 = stage i
- `op_valid` out 1: registered; operands valid this cycle
- `stall_out` out 1: combinational stall request to fetch/decode

## Operation
- Match for operand X at stage i: `stg_we[i]` and `stg_rd[i]==rs_X` and not (`ZERO_REG` and `rs_X==0`).
- Priority: the lowest matching stage index wins. With no match, the register file is used. With `ZERO_REG` and `rs_X==0`, the operand is 0 and sel is 0.
- Load-use hazard: `in_valid`, a stage-0 match on `rs_a` or `rs_b`, and `stg_load0`.
- FSM states and transitions:
  - RUN → STALL on hazard. The counter loads `LOAD_LAT-1`. If `LOAD_LAT==1`, the FSM stays in RUN, because the hazard clears once upstream inserts a bubble.
  - STALL: the counter decrements each non-hold cycle. At 0, STALL → RUN.
- `stall_out` = (RUN and hazard) or STALL; it is forced 0 while `reset`.
- Capture: on a non-hold edge with `in_valid` and no `stall_out`, the unit registers `op_a`, `op_b`, `sel_a`, `sel_b` and sets `op_valid`=1. Otherwise `op_valid`=0 on that edge and the operand/sel registers keep their old value.
- Simultaneous match of the same register in several stages: the youngest stage wins, whether or not it is a load. If it is a load, the hazard fires.
- Both operands are the same register: both forward from the same source.

## Timing
- Reset values (edge with `reset`=1): `op_a`=`op_b`=0, `sel_a`=`sel_b`=0, `op_valid`=0, state RUN, counter 0.
- Reset overrides `hold`. Reset mid-STALL returns the FSM to RUN immediately.
- Latency: inputs sampled at edge N appear on outputs after edge N, i.e. one cycle.
- `stall_out` asserts in the same cycle as the hazard inputs. It stays high for exactly `LOAD_LAT` non-hold cycles in total.
- `hold`=1: no state changes. `stall_out` keeps its current combinational value.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `REG_AW`, FSM state enum (RUN, STALL), sel encoding constant `SEL_RF`=0.
- One sub-module `fwd_select`, instantiated once per operand. It is combinational: priority match plus mux over `STAGES`, and outputs data and sel.
- The top level holds the operand registers, the hazard detect logic and the FSM/counter.

## Test plan
- No match: `rs_a`=3, `rf_a`=0x1111, all `stg_we`=0 → next cycle `op_a`=0x1111, `sel_a`=0, `op_valid`=1.
- Priority: `rs_b`=5, stage 0 and stage 1 both write r5 with 0xAAAA / 0xBBBB, `stg_load0`=0 → `op_b`=0xAAAA, `sel_b`=1.
- Zero register: `rs_a`=0, stage 0 writes r0 with 0xFFFF, `ZERO_REG`=1 → `op_a`=0, `sel_a`=0.
- Load-use: `LOAD_LAT`=2, `rs_a`=4, stage 0 is a load to r4 → `stall_out` high for 2 cycles and `op_valid`=0 during them. With the load then in stage 1 with data 0x1234 → `op_a`=0x1234, `sel_a`=2.
- Hold: `hold`=1 for 3 cycles mid-STALL → counter, outputs and `op_valid` frozen; stall then completes the remaining cycles after release.
- Reset mid-STALL: `reset` asserted during STALL → next cycle state RUN, all outputs 0, `stall_out`=0 absent a new hazard.
